cam_frame_vga_reader: RTL and testbench

- Downstream consumer of the camera capture RAM.
- The capture stage fills a 160x120, 8-bit RGB332 frame buffer at 15-bit addresses.
- This block generates 640x480@60 VGA timing from the single system clock, reads the buffer with 4x nearest-neighbour upscaling, and drives 4-bit-per-channel RGB plus HS/VS to the display pins.

---
 rtl/cam_frame_vga_reader_if.sv | 26 ++
 rtl/cam_frame_vga_reader.sv | 125 ++++++++++++
 tb/tb_cam_frame_vga_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_frame_vga_reader_if.sv
// Frame-RAM read port and VGA pin bundle for cam_frame_vga_reader.
// The master modport is the reader; the slave modport is the RAM and display side.
interface cam_frame_vga_reader_if;
  logic [7:0]  i_RAM_Data;
  logic [14:0] o_RAM_Adress;
  logic        o_RAM_Read_Enable;
  logic [3:0]  o_Red;
  logic [3:0]  o_Green;
  logic [3:0]  o_Blue;
  logic        o_HS;
  logic        o_VS;
  logic        o_Active;
  logic        o_Frame_Done;

  modport master (
    input  i_RAM_Data,
    output o_RAM_Adress, o_RAM_Read_Enable, o_Red, o_Green, o_Blue,
    output o_HS, o_VS, o_Active, o_Frame_Done
  );

  modport slave (
    output i_RAM_Data,
    input  o_RAM_Adress, o_RAM_Read_Enable, o_Red, o_Green, o_Blue,
    input  o_HS, o_VS, o_Active, o_Frame_Done
  );
endinterface

// File: rtl/cam_frame_vga_reader.sv
// VGA timing generator that reads a small RGB332 frame buffer with nearest-neighbour
// upscaling and drives 4-bit-per-channel RGB plus active-low syncs.
module cam_frame_vga_reader #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic                          i_Clk,
  input  logic                          i_Reset_n,
  input  logic                          i_Enable,
  cam_frame_vga_reader_if.master        io_Bus
);
  localparam int unsigned HTot = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTot = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);
  localparam int unsigned DW   = $clog2(CLK_DIV);
  localparam int unsigned AW   = 15;

  localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HLast   = HW'(HTot - 1);
  localparam logic [VW-1:0] VLast   = VW'(VTot - 1);
  localparam logic [HW-1:0] HAct    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] VAct    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HsBeg   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HsEnd   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VsBeg   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VsEnd   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_hs_raw, r_vs_raw, r_act_raw;
  logic          r_re, r_re_d, r_fd;
  logic [7:0]    r_pix;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_red, r_grn, r_blu;
  logic          r_hs, r_vs, r_act;

  logic          w_tick, w_vis, w_hs_raw, w_vs_raw;
  logic [AW-1:0] w_addr;

  assign w_tick   = (r_div == DivLast);
  assign w_vis    = (r_h < HAct) && (r_v < VAct);
  assign w_hs_raw = !((r_h >= HsBeg) && (r_h < HsEnd));
  assign w_vs_raw = !((r_v >= VsBeg) && (r_v < VsEnd));
  // Constant-coefficient multiply; synthesis reduces it to shift-add.
  assign w_addr   = AW'(r_v >> SCALE_SHIFT) * AW'(IMG_W) + AW'(r_h >> SCALE_SHIFT);

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n || !i_Enable) begin
      r_div     <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_hs_raw  <= 1'b1;
      r_vs_raw  <= 1'b1;
      r_act_raw <= 1'b0;
      r_re      <= 1'b0;
      r_re_d    <= 1'b0;
      r_fd      <= 1'b0;
      r_pix     <= '0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_act     <= 1'b0;
      if (!i_Reset_n) r_addr <= '0;
    end else begin
      r_re   <= 1'b0;
      r_fd   <= 1'b0;
      r_re_d <= r_re;
      // RAM data is valid the clock after the read strobe; CLK_DIV >= 3 keeps this
      // capture ahead of the next tick.
      if (r_re_d) r_pix <= io_Bus.i_RAM_Data;
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        if (r_h == HLast) begin
          r_h <= '0;
          r_v <= (r_v == VLast) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
        if (w_vis) begin
          r_addr <= w_addr;
          r_re   <= 1'b1;
        end
        r_hs_raw  <= w_hs_raw;
        r_vs_raw  <= w_vs_raw;
        r_act_raw <= w_vis;
        r_fd      <= (r_h == HLast) && (r_v == VLast);
        r_hs      <= r_hs_raw;
        r_vs      <= r_vs_raw;
        r_act     <= r_act_raw;
        if (r_act_raw) begin
          r_red <= {r_pix[7:5], r_pix[7]};
          r_grn <= {r_pix[4:2], r_pix[4]};
          r_blu <= {r_pix[1:0], r_pix[1:0]};
        end else begin
          r_red <= '0;
          r_grn <= '0;
          r_blu <= '0;
        end
      end
    end
  end

  assign io_Bus.o_RAM_Adress      = r_addr;
  assign io_Bus.o_RAM_Read_Enable = r_re;
  assign io_Bus.o_Red             = r_red;
  assign io_Bus.o_Green           = r_grn;
  assign io_Bus.o_Blue            = r_blu;
  assign io_Bus.o_HS              = r_hs;
  assign io_Bus.o_VS              = r_vs;
  assign io_Bus.o_Active          = r_act;
  assign io_Bus.o_Frame_Done      = r_fd;
endmodule

// File: tb/tb_cam_frame_vga_reader.sv
// Bench for cam_frame_vga_reader using a shrunken raster so whole frames fit in a short run;
// a per-clock scoreboard plus directed timing measurements.
module tb_cam_frame_vga_reader;
  localparam int unsigned D = 4;
  localparam int HA = 32, HFP = 4, HSW = 8, HBP = 4;
  localparam int VA = 16, VFP = 2, VSW = 2, VBP = 3;
  localparam int IW = 8, SS = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT * int'(D);

  typedef struct packed {
    logic [3:0] r, g, b;
    logic hs, vs, act;
  } pix_t;

  typedef struct packed {
    logic        re;
    logic [14:0] addr;
    pix_t        o;
    logic        fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [7:0] ram_q = 8'h00;
  logic [7:0] mem [0:32767];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  exp_t q[$];

  cam_frame_vga_reader_if bus ();

  cam_frame_vga_reader #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .IMG_W(IW), .SCALE_SHIFT(SS)
  ) dut (
    .i_Clk    (clk),
    .i_Reset_n(rst_n),
    .i_Enable (en),
    .io_Bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM; between reads its output is garbage the DUT must ignore.
  always @(posedge clk) begin
    if (bus.o_RAM_Read_Enable) ram_q <= mem[bus.o_RAM_Adress];
    else ram_q <= 8'($urandom);
  end
  assign bus.i_RAM_Data = ram_q;

  function automatic logic [14:0] addr_of(input int h, input int v);
    return 15'((v >> SS) * IW + (h >> SS));
  endfunction

  function automatic pix_t idle_out();
    pix_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Expected pins for raster pixel index j (counted from (0,0) of the first frame).
  function automatic pix_t pix_out(input longint j);
    pix_t o;
    int h, v, d;
    h = int'(j % HT);
    v = int'((j / HT) % VT);
    o = '0;
    o.hs  = !(h >= HA + HFP && h < HA + HFP + HSW);
    o.vs  = !(v >= VA + VFP && v < VA + VFP + VSW);
    o.act = (h < HA) && (v < VA);
    if (o.act) begin
      d = int'(mem[addr_of(h, v)]);
      o.r = 4'((d >> 5) * 2 + (d >> 7));
      o.g = 4'(((d >> 2) & 7) * 2 + ((d >> 4) & 1));
      o.b = 4'((d & 3) * 4 + (d & 3));
    end
    return o;
  endfunction

  // Reference model: pixel k is issued on the k-th divider tick since (re)start and shows
  // on the pins at the following tick.
  longint      m_n = 0;
  logic [14:0] m_addr = '0;
  pix_t        m_o;
  always @(posedge clk) begin
    logic re, fd;
    longint k;
    int h, v;
    re = 1'b0;
    fd = 1'b0;
    if (!rst_n) begin
      m_n = 0;
      m_addr = '0;
      m_o = idle_out();
    end else if (!en) begin
      m_n = 0;
      m_o = idle_out();
    end else begin
      if (m_n % D == D - 1) begin
        k = m_n / D;
        h = int'(k % HT);
        v = int'((k / HT) % VT);
        if (h < HA && v < VA) begin
          re = 1'b1;
          m_addr = addr_of(h, v);
        end
        fd = (h == HT - 1) && (v == VT - 1);
        m_o = (k == 0) ? idle_out() : pix_out(k - 1);
      end
      m_n++;
    end
    q.push_back({re, m_addr, m_o, fd});
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e, g;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = {bus.o_RAM_Read_Enable, bus.o_RAM_Adress,
           bus.o_Red, bus.o_Green, bus.o_Blue, bus.o_HS, bus.o_VS, bus.o_Active,
           bus.o_Frame_Done};
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL pins@cyc%0d: got re=%b a=%0d rgb=%h%h%h hs=%b vs=%b act=%b fd=%b, want re=%b a=%0d rgb=%h%h%h hs=%b vs=%b act=%b fd=%b",
                 cyc, g.re, g.addr, g.o.r, g.o.g, g.o.b, g.o.hs, g.o.vs, g.o.act, g.fd,
                 e.re, e.addr, e.o.r, e.o.g, e.o.b, e.o.hs, e.o.vs, e.o.act, e.fd);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Counts clocks up to and including the next frame-done pulse, tallying pin activity.
  task automatic run_frame(output int clks, output int hs_lo, output int vs_lo,
                           output int act, output int rd);
    clks = 0; hs_lo = 0; vs_lo = 0; act = 0; rd = 0;
    while (clks < 2 * FRAME) begin
      @(negedge clk);
      clks++;
      hs_lo += int'(!bus.o_HS);
      vs_lo += int'(!bus.o_VS);
      act   += int'(bus.o_Active);
      rd    += int'(bus.o_RAM_Read_Enable);
      if (bus.o_Frame_Done) break;
    end
  endtask

  task automatic wait_for(input string name, input int which, input int want);
    int c;
    logic hit;
    c = 0;
    hit = 1'b0;
    while (c < 64 && !hit) begin
      @(negedge clk);
      c++;
      hit = (which == 0) ? bus.o_RAM_Read_Enable : bus.o_Active;
    end
    chk(name, hit ? c : -1, want);
  endtask

  initial begin
    int clks, hs_lo, vs_lo, act, rd;
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    mem[1] = 8'h1C;
    mem[2] = 8'h03;
    mem[3] = 8'hFF;

    // Reset held with enable high, then first read after release.
    repeat (10) @(negedge clk);
    chk("reset_hs", bus.o_HS, 1);
    chk("reset_act", bus.o_Active, 0);
    rst_n = 1'b1;
    wait_for("first_read_latency", 0, 4);
    chk("first_read_addr", bus.o_RAM_Adress, 0);

    // First frame from release, then one full steady-state frame.
    run_frame(clks, hs_lo, vs_lo, act, rd);
    chk("frame_from_release", clks + 4, FRAME);
    run_frame(clks, hs_lo, vs_lo, act, rd);
    chk("frame_period", clks, FRAME);
    chk("hs_low_clocks", hs_lo, HSW * int'(D) * VT);
    chk("vs_low_clocks", vs_lo, VSW * HT * int'(D));
    chk("active_clocks", act, HA * int'(D) * VA);
    chk("reads_per_frame", rd, HA * VA);

    // Drop enable mid-line at (20,10), then restart.
    repeat ((10 * HT + 20) * int'(D) + 3) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("disabled_hs", bus.o_HS, 1);
    chk("disabled_rgb", {bus.o_Red, bus.o_Green, bus.o_Blue}, 0);
    en = 1'b1;
    wait_for("first_visible_after_enable", 1, 8);

    // One-clock reset at line 12; next frame done a full frame after release.
    repeat (12 * HT * int'(D)) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_vs", bus.o_VS, 1);
    rst_n = 1'b1;
    run_frame(clks, hs_lo, vs_lo, act, rd);
    chk("frame_after_midreset", clks, FRAME);

    // Random enable gaps and occasional resets, checked by the scoreboard.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 299) != 0);
      rst_n = ($urandom_range(0, 1999) != 0);
    end
    rst_n = 1'b1;
    en = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
